// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit with HI/LO; result commits MUL_CYCLES/DIV_CYCLES after launch.
// No backpressure: busy = start | busy_q stalls the pipeline. MDU_MADD_EN enables madd/msub (op 6/7).
module mdu_core #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    logic [3:0]  cnt, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    state_t      state;
    logic        busy_q;
    logic        launch_ok;

    assign state  = (cnt == 4'd0) ? IDLE : RUN;
    assign busy_q = (state == RUN);
    assign busy   = start | busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

`ifdef MDU_MADD_EN
    assign launch_ok = (op != OP_MTHI) && (op != OP_MTLO);
`else
    assign launch_ok = ~op[2];
`endif

    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // One unsigned divider serves both div and divu; signed divide works on magnitudes.
    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000, positive sign.
    logic        div_signed;
    logic [31:0] dvd, dvs, uq, ur, quo, rem;
    assign div_signed = (op_q == OP_DIV);
    assign dvd = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign dvs = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign uq  = dvd / dvs;
    assign ur  = dvd % dvs;
    assign quo = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
    assign rem = (div_signed && a_q[31]) ? (32'd0 - ur) : ur;

`ifdef MDU_MADD_EN
    // HI/LO cannot change while RUN, so the current value is the launch-time base.
    logic [63:0] acc_add, acc_sub;
    assign acc_add = {hi_q, lo_q} + prod_s;
    assign acc_sub = {hi_q, lo_q} - prod_s;
`endif

    always_comb begin
        cnt_d = cnt;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (launch_ok) begin
                        op_d  = op;
                        a_d   = a;
                        b_d   = b;
                        cnt_d = (op == OP_DIV || op == OP_DIVU) ? DIV_CNT : MUL_CNT;
                    end
                end else if (we) begin
                    if (op == OP_MTHI) hi_d = a;
                    else if (op == OP_MTLO) lo_d = a;
                end
            end
            RUN: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = acc_add;
                        OP_MSUB:  {hi_d, lo_d} = acc_sub;
`endif
                        default: ;
                    endcase
                end
            end
            default: cnt_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= 4'd0;
            op_q <= 3'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            cnt  <= cnt_d;
            op_q <= op_d;
            a_q  <= a_d;
            b_q  <= b_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_core.sv
// Directed bench for mdu_core: latency, HI/LO results, div-by-zero, mid-run reset, mthi/mtlo, madd.
module tb_mdu_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        we;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_core #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .we    (we),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream protocol: no start/we while a multi-cycle op is in flight.
    always @(posedge clk) begin
        assert (!(reset && dut.busy_q && (start || we)))
        else begin
            errors++;
            $error("FAIL protocol: start=%0b we=%0b while busy_q", start, we);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch at a negedge, count busy cycles (launch included), return on the first non-busy negedge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int exp_busy, input string tag);
        int n;
        logic [63:0] prev;
        logic held;
        start = 1'b1; op = o; a = x; b = y;
        #1;
        check({tag, "_launch_busy"}, {63'd0, busy}, 64'd1);
        prev = {hi, lo};
        held = 1'b1;
        n = 1;
        @(negedge clk);
        start = 1'b0; a = 32'd0; b = 32'd0;
        #1;
        while (busy && n < 40) begin
            n++;
            if ({hi, lo} !== prev) held = 1'b0;
            @(negedge clk);
            #1;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        check({tag, "_hilo_held"}, {63'd0, held}, 64'd1);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        we = 1'b1; op = o; a = v;
        #1;
        check("mt_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        we = 1'b0; a = 32'd0;
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; we = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 6, "mult");
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

        run_op(3'd3, 32'd100, 32'd7, 11, "divu");
        check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 11, "div_neg");
        check("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 11, "div_ovf");
        check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        mt(3'd5, 32'h1234);
        check("mtlo_hilo", {hi, lo}, 64'h00000000_00001234);
        run_op(3'd2, 32'd5, 32'd0, 11, "div0");
        check("div0_hilo", {hi, lo}, 64'h00000000_00001234);

        // start with op=mthi and we together: start wins, and op 4 launches nothing.
        start = 1'b1; we = 1'b1; op = 3'd4; a = 32'd99;
        #1;
        check("noop_busy_launch", {63'd0, busy}, 64'd1);
        @(negedge clk);
        start = 1'b0; we = 1'b0; a = 32'd0;
        #1;
        check("noop_busy_after", {63'd0, busy}, 64'd0);
        check("noop_hilo", {hi, lo}, 64'h00000000_00001234);

        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("rst_after_busy", {63'd0, busy}, 64'd0);
        check("rst_after_hilo", {hi, lo}, 64'd0);
        run_op(3'd0, 32'd6, 32'd7, 6, "mult_post_rst");
        check("mult_post_rst_hilo", {hi, lo}, 64'd42);

        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, "multu");
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        mt(3'd4, 32'd5);
        check("mthi_hilo", {hi, lo}, 64'h00000005_00000001);

        mt(3'd4, 32'd0);
        mt(3'd5, 32'd10);
        check("pre_madd_hilo", {hi, lo}, 64'd10);
`ifdef MDU_MADD_EN
        run_op(3'd6, 32'd3, 32'd4, 6, "madd");
        check("madd_hilo", {hi, lo}, 64'd22);
`else
        run_op(3'd6, 32'd3, 32'd4, 1, "madd_off");
        check("madd_off_hilo", {hi, lo}, 64'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
